// File: rtl/settings_pkg.sv
// Shared types, field limits and encodings for the settings menu.
package settings_pkg;

  typedef enum logic [2:0] {StIdle, StSelMode, StSelDiff, StSelSpeed, StCommit} menu_state_t;

  localparam logic [1:0] MODE_MAX        = 2'd1;
  localparam logic [2:0] DIFF_MAX        = 3'd2;
  localparam logic [1:0] SPEED_MAX       = 2'd1;
  localparam logic [1:0] MENU_FIELD_NONE = 2'd3;

  localparam logic [1:0] MODE_SOLO  = 2'd0;
  localparam logic [1:0] MODE_TWO   = 2'd1;
  localparam logic [2:0] DIFF_EASY  = 3'd0;
  localparam logic [2:0] DIFF_MED   = 3'd1;
  localparam logic [2:0] DIFF_HARD  = 3'd2;
  localparam logic [1:0] SPEED_SLOW = 2'd0;
  localparam logic [1:0] SPEED_FAST = 2'd1;

  // Anything at or above the maximum (including forced out-of-range) wraps to 0.
  function automatic logic [2:0] wrap_inc(logic [2:0] val, logic [2:0] max);
    return (val >= max) ? 3'd0 : val + 3'd1;
  endfunction

  function automatic menu_state_t next_sel(menu_state_t s);
    unique case (s)
      StSelMode: return StSelDiff;
      StSelDiff: return StSelSpeed;
      default:   return StCommit;
    endcase
  endfunction

  function automatic logic [1:0] field_of(menu_state_t s);
    unique case (s)
      StSelMode:  return 2'd0;
      StSelDiff:  return 2'd1;
      StSelSpeed: return 2'd2;
      default:    return MENU_FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/settings_if.sv
// Committed game configuration, driven by the menu and read by sequencer/timers.
interface settings_if;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_difficulty;
  logic [1:0] cfg_speed;

  modport producer (output cfg_mode, output cfg_difficulty, output cfg_speed);
  modport consumer (input cfg_mode, input cfg_difficulty, input cfg_speed);
endinterface

// File: rtl/menu_timeout_timer.sv
// Idle counter for the edit states; expire is high in the cycle the count reaches its last value.
module menu_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt;

  assign expire = run && (cnt == CntLast);

  always_ff @(posedge clk) begin
    if (!rst_n || !run || clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/settings_menu_ctrl.sv
// Three-field settings editor: edits land in shadow registers and reach cfg only on commit.
module settings_menu_ctrl
  import settings_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned RST_MODE       = 0,
  parameter int unsigned RST_DIFFICULTY = 0,
  parameter int unsigned RST_SPEED      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_menu,
  input  logic                btn_inc,
  input  logic                btn_next,
  input  logic                game_active,
  settings_if.producer        cfg,
  output logic                edit_active,
  output logic [1:0]          menu_field,
  output logic                cfg_updated,
  output logic                edit_timeout
);

  localparam logic [1:0] RstMode  = RST_MODE[1:0];
  localparam logic [2:0] RstDiff  = RST_DIFFICULTY[2:0];
  localparam logic [1:0] RstSpeed = RST_SPEED[1:0];

  menu_state_t state;
  logic [1:0]  shadow_mode;
  logic [2:0]  shadow_diff;
  logic [1:0]  shadow_speed;
  logic        in_sel;
  logic        expire;

  assign in_sel = (state == StSelMode) || (state == StSelDiff) || (state == StSelSpeed);

  // Any button or a running game restarts the idle count; run low holds it at zero.
  menu_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (in_sel),
    .clear (btn_menu | btn_inc | btn_next | game_active),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= StIdle;
      shadow_mode        <= RstMode;
      shadow_diff        <= RstDiff;
      shadow_speed       <= RstSpeed;
      cfg.cfg_mode       <= RstMode;
      cfg.cfg_difficulty <= RstDiff;
      cfg.cfg_speed      <= RstSpeed;
      edit_active        <= 1'b0;
      menu_field         <= MENU_FIELD_NONE;
      cfg_updated        <= 1'b0;
      edit_timeout       <= 1'b0;
    end else begin
      cfg_updated  <= 1'b0;
      edit_timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (btn_menu && !game_active) begin
            state        <= StSelMode;
            edit_active  <= 1'b1;
            menu_field   <= field_of(StSelMode);
            shadow_mode  <= cfg.cfg_mode;
            shadow_diff  <= cfg.cfg_difficulty;
            shadow_speed <= cfg.cfg_speed;
          end
        end
        StSelMode, StSelDiff, StSelSpeed: begin
          if (game_active || btn_menu || expire) begin
            state        <= StIdle;
            edit_active  <= 1'b0;
            menu_field   <= MENU_FIELD_NONE;
            edit_timeout <= !(game_active || btn_menu);
          end else if (btn_next) begin
            state       <= next_sel(state);
            edit_active <= (next_sel(state) != StCommit);
            menu_field  <= field_of(next_sel(state));
          end else if (btn_inc) begin
            unique case (state)
              StSelMode:  shadow_mode  <= 2'(wrap_inc(3'(shadow_mode), 3'(MODE_MAX)));
              StSelDiff:  shadow_diff  <= wrap_inc(shadow_diff, DIFF_MAX);
              default:    shadow_speed <= 2'(wrap_inc(3'(shadow_speed), 3'(SPEED_MAX)));
            endcase
          end
        end
        StCommit: begin
          state              <= StIdle;
          cfg.cfg_mode       <= shadow_mode;
          cfg.cfg_difficulty <= shadow_diff;
          cfg.cfg_speed      <= shadow_speed;
          cfg_updated        <= (shadow_mode != cfg.cfg_mode) ||
                                (shadow_diff != cfg.cfg_difficulty) ||
                                (shadow_speed != cfg.cfg_speed);
        end
        default: begin
          state       <= StIdle;
          edit_active <= 1'b0;
          menu_field  <= MENU_FIELD_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_settings_menu_ctrl.sv
// Directed plus randomized bench for settings_menu_ctrl against a field-level reference model.
module tb_settings_menu_ctrl;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_menu = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_next = 1'b0;
  logic       game_active = 1'b0;
  logic       edit_active;
  logic [1:0] menu_field;
  logic       cfg_updated;
  logic       edit_timeout;

  settings_if cfg_bus ();

  settings_menu_ctrl #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_menu    (btn_menu),
    .btn_inc     (btn_inc),
    .btn_next    (btn_next),
    .game_active (game_active),
    .cfg         (cfg_bus),
    .edit_active (edit_active),
    .menu_field  (menu_field),
    .cfg_updated (cfg_updated),
    .edit_timeout(edit_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit ga_level = 1'b0;

  // Model: field -1 = not editing, 0..2 = editing that field, 3 = commit pending.
  int m_field = -1;
  int m_sh[3];
  int m_cfg[3];
  int m_idle = 0;
  bit m_upd = 1'b0;
  bit m_to = 1'b0;
  int fmax[3] = '{1, 2, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit m, input bit i, input bit n, input bit g, input bit r);
    m_upd = 1'b0;
    m_to  = 1'b0;
    if (!r) begin
      m_field = -1;
      m_idle  = 0;
      for (int k = 0; k < 3; k++) begin
        m_sh[k]  = 0;
        m_cfg[k] = 0;
      end
    end else if (m_field == -1) begin
      if (m && !g) begin
        m_sh    = m_cfg;
        m_field = 0;
        m_idle  = 0;
      end
    end else if (m_field == 3) begin
      m_upd   = (m_sh != m_cfg);
      m_cfg   = m_sh;
      m_field = -1;
    end else begin
      if (g || m) begin
        m_field = -1;
        m_idle  = 0;
      end else if (m_idle == TO - 1) begin
        m_field = -1;
        m_to    = 1'b1;
        m_idle  = 0;
      end else if (n) begin
        m_field++;
        m_idle = 0;
      end else if (i) begin
        m_sh[m_field] = (m_sh[m_field] >= fmax[m_field]) ? 0 : m_sh[m_field] + 1;
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  function automatic logic [6:0] cfg_obs();
    return {cfg_bus.cfg_mode, cfg_bus.cfg_difficulty, cfg_bus.cfg_speed};
  endfunction

  task automatic step(input bit m, input bit i, input bit n, input bit r);
    logic [6:0] exp_cfg;
    logic [31:0] c0, c1, c2;
    btn_menu    = m;
    btn_inc     = i;
    btn_next    = n;
    game_active = ga_level;
    rst_n       = r;
    @(posedge clk);
    model_step(m, i, n, ga_level, r);
    #1;
    c0 = m_cfg[0];
    c1 = m_cfg[1];
    c2 = m_cfg[2];
    exp_cfg = {c0[1:0], c1[2:0], c2[1:0]};
    check("edit_active", 32'(edit_active), 32'(m_field >= 0 && m_field <= 2));
    check("menu_field", 32'(menu_field), (m_field >= 0 && m_field <= 2) ? m_field : 3);
    check("cfg", 32'(cfg_obs()), 32'(exp_cfg));
    check("cfg_updated", 32'(cfg_updated), 32'(m_upd));
    check("edit_timeout", 32'(edit_timeout), 32'(m_to));
    btn_menu = 1'b0;
    btn_inc  = 1'b0;
    btn_next = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("reset_cfg", 32'(cfg_obs()), 32'(0));

    // Walk all fields, net result speed = 1
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    check("s1_cfg", 32'(cfg_obs()), 32'(7'b00_000_01));
    check("s1_updated", 32'(cfg_updated), 32'(1));
    idle(2);

    // Difficulty wrap 1, 2, 0, 1
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    check("s2_diff", 32'(cfg_bus.cfg_difficulty), 32'(1));
    idle(1);

    // Game lock
    ga_level = 1'b1;
    step(1, 0, 0, 1);
    check("s3_locked", 32'(edit_active), 32'(0));
    ga_level = 1'b0;
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    ga_level = 1'b1;
    step(0, 0, 0, 1);
    ga_level = 1'b0;
    idle(2);

    // Timeout, then timeout restarted by a press
    step(1, 0, 0, 1);
    idle(TO - 1);
    check("s4_not_yet", 32'(edit_active), 32'(1));
    step(0, 0, 0, 1);
    check("s4_timeout", 32'(edit_timeout), 32'(1));
    idle(2);
    step(1, 0, 0, 1);
    idle(9);
    step(0, 1, 0, 1);
    idle(TO);
    idle(2);

    // next beats inc; no-change commit gives no pulse
    step(1, 0, 0, 1);
    step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    check("s5_no_update", 32'(cfg_updated), 32'(0));
    idle(1);

    // Reset mid-edit after committing mode = 1
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1);
    idle(2);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    check("s6_cfg", 32'(cfg_obs()), 32'(0));
    check("s6_field", 32'(menu_field), 32'(3));
    idle(1);

    // Random traffic with occasional quiet stretches so timeouts occur
    for (int blk = 0; blk < 20; blk++) begin
      bit quiet;
      quiet = (blk % 3 == 2);
      for (int c = 0; c < 150; c++) begin
        bit m, i, n, r;
        m = ($urandom_range(0, quiet ? 60 : 10) == 0);
        i = quiet ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 3) == 0);
        n = quiet ? ($urandom_range(0, 50) == 0) : ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, quiet ? 300 : 40) == 0) ga_level = ~ga_level;
        r = ($urandom_range(0, 400) != 0);
        step(m, i, n, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/settings_menu_ctrl.md
Name: settings_menu_ctrl

Overview:
- User-facing settings editor: the upstream producer of the shared settings interface (producer modport).
- Consumes debounced single-cycle button pulses and walks a 3-field menu: mode, difficulty, speed.
- Edits go to shadow registers. The game sequencer and timers (consumer modport) see a new configuration only on commit.
- Editing is locked while a game is running. An idle timeout discards uncommitted edits.

Parameters:
- TIMEOUT_CYCLES, default 500_000_000, is the number of idle cycles in an edit state before auto-cancel (10 s at 50 MHz). Minimum value is 2.
- RST_MODE, default 0, is the cfg_mode value after reset (Solo).
- RST_DIFFICULTY, default 0, is the cfg_difficulty value after reset (Easy).
- RST_SPEED, default 0, is the cfg_speed value after reset (Slow).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- btn_menu  input  1  pulse: open menu / cancel edit
- btn_inc  input  1  pulse: increment current field, with wrap
- btn_next  input  1  pulse: advance to next field; on the last field, commit
- game_active  input  1  level: game in progress, editing locked
- cfg  interface  settings_if.producer  drives cfg_mode[1:0], cfg_difficulty[2:0], cfg_speed[1:0]
- edit_active  output  1  high in any SEL_* state
- menu_field  output  2  current field for display: 0 = mode, 1 = difficulty, 2 = speed, 3 = none
- cfg_updated  output  1  one-cycle pulse when the committed config changes
- edit_timeout  output  1  one-cycle pulse on auto-cancel

Behaviour:
- Reset, sampled on rising clk while rst_n = 0:
  - state = IDLE; shadow registers and cfg outputs = RST_* values.
  - edit_active = 0, menu_field = 3, cfg_updated = 0, edit_timeout = 0, timeout counter = 0.
  - Reset mid-edit discards shadow edits and restores the RST_* values, not the last committed values.
- States: IDLE, SEL_MODE, SEL_DIFF, SEL_SPEED, COMMIT.
- IDLE:
  - btn_menu while game_active = 0: load shadow from the current cfg outputs, go to SEL_MODE.
  - btn_menu while game_active = 1 is ignored. btn_inc and btn_next are ignored.
- SEL_* states, evaluated in priority order:
  1. game_active = 1 or btn_menu: cancel. Go to IDLE, shadow discarded, cfg unchanged, no pulse.
  2. Timeout expiry: go to IDLE, edit_timeout = 1 for one cycle, cfg unchanged.
  3. btn_next: SEL_MODE goes to SEL_DIFF, SEL_DIFF goes to SEL_SPEED, SEL_SPEED goes to COMMIT.
  4. btn_inc: shadow field of the current state increments by 1, with wrap.
  - When btn_next and btn_inc are asserted in the same cycle, next wins and inc is dropped.
- Wrap rules:
  - Mode: 0 to 1, then 1 to 0.
  - Difficulty: 0 to 1 to 2, then 2 to 0.
  - Speed: 0 to 1, then 1 to 0.
  - Out-of-range values are unreachable. If forced, the next increment loads 0.
- COMMIT, one cycle:
  - cfg outputs <= shadow.
  - cfg_updated = 1 in the following cycle only if any field differs from the previous cfg; otherwise 0.
  - Then go to IDLE. Buttons are ignored during COMMIT.
- Latency:
  - A button pulse in cycle N updates state/shadow at the edge ending cycle N.
  - Commit: btn_next in SEL_SPEED at cycle N puts the FSM in COMMIT at N+1. New cfg values and cfg_updated are visible at N+2.
- Timeout counter:
  - Clears on SEL_* entry and on any accepted btn_inc or btn_next. Otherwise increments in SEL_* states.
  - Expiry occurs when the count equals TIMEOUT_CYCLES-1. The counter is held at 0 outside SEL_* states.
  - Width is $clog2(TIMEOUT_CYCLES).
- menu_field and edit_active are registered, decoded from state. menu_field = 3 in IDLE and COMMIT.
- cfg outputs are registered and stable except on the COMMIT edge. They never glitch during edits.

Decomposition:
- settings_pkg holds:
  - menu_state_t enum.
  - Field maxima: MODE_MAX = 1, DIFF_MAX = 2, SPEED_MAX = 1.
  - MENU_FIELD_NONE = 3.
  - Encoding constants: MODE_SOLO/MODE_TWO, DIFF_EASY/MED/HARD, SPEED_SLOW/FAST.
- One sub-module: menu_timeout_timer.
  - Parameter: TIMEOUT_CYCLES.
  - Inputs: clk, rst_n, run, clear.
  - Output: expire pulse.

Test Plan:
All scenarios use TIMEOUT_CYCLES = 16.
1. Reset, then btn_menu; btn_inc twice; btn_next; btn_inc three times; btn_next; btn_inc; btn_next -> cfg = (mode 0, diff 0, speed 1) two cycles after the last next; cfg_updated pulses once.
2. Wrap check: in SEL_DIFF from 0, press btn_inc four times -> shadow goes 1, 2, 0, 1. Commit -> cfg_difficulty = 1.
3. game_active held at 1, then btn_menu -> state stays IDLE, edit_active = 0. Next, enter SEL_DIFF, then raise game_active -> IDLE next cycle, cfg unchanged, no cfg_updated.
4. Enter the menu and idle 16 cycles -> edit_timeout pulses once, menu_field = 3, cfg unchanged. Repeat with btn_inc at cycle 10 -> no timeout until 16 cycles after that press.
5. btn_next and btn_inc in the same cycle in SEL_MODE -> SEL_DIFF, mode shadow unchanged. Commit with no changes -> cfg_updated stays 0.
6. Assert rst_n = 0 mid-edit after committing mode = 1 -> cfg returns to (0, 0, 0), state IDLE.
